// File: rtl/liteic_pkg.sv
// Shared definitions for the liteic AXI-Lite crossbar: slot counts, address map, read FSM states.
// LITEIC_DECERR_EN adds the R_ERR state used to answer unmapped reads locally.
package liteic_pkg;

  localparam int IC_NUM_SLAVE_SLOTS = 4;
  localparam int IC_ARADDR_WIDTH    = 32;
  localparam int IC_DATA_WIDTH      = 32;
  localparam int IC_RDATA_WIDTH     = IC_DATA_WIDTH + 2;

  // Index 0 is the rightmost entry; slot 0 doubles as the default slave.
  localparam logic [IC_NUM_SLAVE_SLOTS-1:0][IC_ARADDR_WIDTH-1:0] IC_SLAVE_BASE = {
    32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000
  };
  localparam logic [IC_NUM_SLAVE_SLOTS-1:0][IC_ARADDR_WIDTH-1:0] IC_SLAVE_MASK = {
    32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000
  };

  localparam logic [1:0] IC_RESP_OKAY   = 2'b00;
  localparam logic [1:0] IC_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_AR_SEND,
`ifdef LITEIC_DECERR_EN
    RD_R_WAIT,
    RD_R_ERR
`else
    RD_R_WAIT
`endif
  } liteic_rd_state_t;

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite read channels as seen between a master and its crossbar node.
// Independent of LITEIC_DECERR_EN.
interface axi_lite_if;
  import liteic_pkg::*;

  logic                       ar_valid;
  logic                       ar_ready;
  logic [IC_ARADDR_WIDTH-1:0] ar_addr;
  logic [3:0]                 ar_qos;
  logic                       r_valid;
  logic                       r_ready;
  logic [IC_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                 r_resp;

  modport master (output ar_valid, ar_addr, ar_qos, r_ready,
                  input  ar_ready, r_valid, r_data, r_resp);
  modport slave  (input  ar_valid, ar_addr, ar_qos, r_ready,
                  output ar_ready, r_valid, r_data, r_resp);
endinterface

// File: rtl/liteic_addr_decoder.sv
// Combinational address-map lookup: one-hot hit vector with lowest-index priority, plus miss flag.
// Shared by the read and write master nodes; unaffected by LITEIC_DECERR_EN.
module liteic_addr_decoder
  import liteic_pkg::*;
(
  input  logic [IC_ARADDR_WIDTH-1:0]    i_addr,
  output logic [IC_NUM_SLAVE_SLOTS-1:0] o_hit,
  output logic                          o_miss
);

  // Scanning downward lets the lowest matching index overwrite any higher match.
  always_comb begin
    o_hit = '0;
    for (int i = IC_NUM_SLAVE_SLOTS - 1; i >= 0; i--) begin
      if ((i_addr & IC_SLAVE_MASK[i]) == IC_SLAVE_BASE[i]) begin
        o_hit    = '0;
        o_hit[i] = 1'b1;
      end
    end
  end

  assign o_miss = ~|o_hit;

endmodule

// File: rtl/liteic_master_node_read.sv
// Per-master read node: decodes AR to a slave column, forwards it, and returns that column's R beat.
// LITEIC_DECERR_EN: unmapped reads get a local DECERR; otherwise they go to slave slot 0.
module liteic_master_node_read
  import liteic_pkg::*;
#(
  parameter int MST_IDX = 0
) (
  input  logic                                                  clk_i,
  input  logic                                                  rstn_i,
  axi_lite_if.slave                                             mst_axil,
  output logic [IC_NUM_SLAVE_SLOTS-1:0][IC_ARADDR_WIDTH-1:0]    cbar_reqst_data_o,
  output logic [IC_NUM_SLAVE_SLOTS-1:0][3:0]                    cbar_reqst_arqos_o,
  output logic [IC_NUM_SLAVE_SLOTS-1:0]                         cbar_reqst_val_o,
  input  logic [IC_NUM_SLAVE_SLOTS-1:0]                         cbar_reqst_rdy_i,
  input  logic [IC_NUM_SLAVE_SLOTS-1:0]                         cbar_resp_val_i,
  input  logic [IC_NUM_SLAVE_SLOTS-1:0][IC_RDATA_WIDTH-1:0]     cbar_resp_data_i,
  output logic [IC_NUM_SLAVE_SLOTS-1:0]                         cbar_resp_rdy_o
);

  localparam int N = IC_NUM_SLAVE_SLOTS;

  if (MST_IDX < 0) begin : g_bad_idx
    $error("MST_IDX must be non-negative");
  end

  liteic_rd_state_t           r_state, w_state_nxt;
  logic [IC_ARADDR_WIDTH-1:0] r_addr;
  logic [3:0]                 r_qos;
  logic [N-1:0]               r_slv_sel;
  logic [N-1:0]               w_hit;
  logic                       w_miss;
  logic [N-1:0]               w_sel_dec;
  logic [IC_RDATA_WIDTH-1:0]  w_resp_mux;
  logic                       w_resp_hit;

  liteic_addr_decoder u_dec (
    .i_addr (mst_axil.ar_addr),
    .o_hit  (w_hit),
    .o_miss (w_miss)
  );

`ifdef LITEIC_DECERR_EN
  assign w_sel_dec = w_hit;
`else
  assign w_sel_dec = w_miss ? {{(N-1){1'b0}}, 1'b1} : w_hit;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state   <= RD_IDLE;
      r_addr    <= '0;
      r_qos     <= '0;
      r_slv_sel <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == RD_IDLE && mst_axil.ar_valid) begin
        r_addr    <= mst_axil.ar_addr;
        r_qos     <= mst_axil.ar_qos;
        r_slv_sel <= w_sel_dec;
      end
    end
  end

  // Address and QoS fan out to every column; only the one-hot valid picks the target.
  assign cbar_reqst_data_o  = {N{r_addr}};
  assign cbar_reqst_arqos_o = {N{r_qos}};

  always_comb begin
    w_resp_mux = '0;
    for (int i = 0; i < N; i++) begin
      w_resp_mux = w_resp_mux | (cbar_resp_data_i[i] & {IC_RDATA_WIDTH{r_slv_sel[i]}});
    end
  end

  assign w_resp_hit = |(cbar_resp_val_i & r_slv_sel);

  always_comb begin
    w_state_nxt       = r_state;
    mst_axil.ar_ready = 1'b0;
    mst_axil.r_valid  = 1'b0;
    mst_axil.r_data   = '0;
    mst_axil.r_resp   = IC_RESP_OKAY;
    cbar_reqst_val_o  = '0;
    cbar_resp_rdy_o   = '0;
    case (r_state)
      RD_IDLE: begin
        mst_axil.ar_ready = 1'b1;
        if (mst_axil.ar_valid) begin
`ifdef LITEIC_DECERR_EN
          w_state_nxt = w_miss ? RD_R_ERR : RD_AR_SEND;
`else
          w_state_nxt = RD_AR_SEND;
`endif
        end
      end
      RD_AR_SEND: begin
        cbar_reqst_val_o = r_slv_sel;
        if (|(cbar_reqst_rdy_i & r_slv_sel)) w_state_nxt = RD_R_WAIT;
      end
      RD_R_WAIT: begin
        mst_axil.r_valid = w_resp_hit;
        mst_axil.r_data  = w_resp_mux[IC_RDATA_WIDTH-1:2];
        mst_axil.r_resp  = w_resp_mux[1:0];
        cbar_resp_rdy_o  = r_slv_sel & {N{mst_axil.r_ready}};
        if (w_resp_hit && mst_axil.r_ready) w_state_nxt = RD_IDLE;
      end
`ifdef LITEIC_DECERR_EN
      RD_R_ERR: begin
        mst_axil.r_valid = 1'b1;
        mst_axil.r_resp  = IC_RESP_DECERR;
        if (mst_axil.r_ready) w_state_nxt = RD_IDLE;
      end
`endif
      default: w_state_nxt = RD_IDLE;
    endcase
  end

endmodule

// File: tb/tb_liteic_master_node_read.sv
// Directed self-checking bench for liteic_master_node_read (either LITEIC_DECERR_EN setting).
module tb_liteic_master_node_read;
  import liteic_pkg::*;

  localparam int N  = IC_NUM_SLAVE_SLOTS;
  localparam int AW = IC_ARADDR_WIDTH;
  localparam int RW = IC_RDATA_WIDTH;

  logic clk = 1'b0;
  logic rstn;
  logic [N-1:0][AW-1:0] reqst_data;
  logic [N-1:0][3:0]    reqst_qos;
  logic [N-1:0]         reqst_val;
  logic [N-1:0]         reqst_rdy;
  logic [N-1:0]         resp_val;
  logic [N-1:0][RW-1:0] resp_data;
  logic [N-1:0]         resp_rdy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  axi_lite_if mst ();

  liteic_master_node_read #(.MST_IDX(0)) dut (
    .clk_i              (clk),
    .rstn_i             (rstn),
    .mst_axil           (mst),
    .cbar_reqst_data_o  (reqst_data),
    .cbar_reqst_arqos_o (reqst_qos),
    .cbar_reqst_val_o   (reqst_val),
    .cbar_reqst_rdy_i   (reqst_rdy),
    .cbar_resp_val_i    (resp_val),
    .cbar_resp_data_i   (resp_data),
    .cbar_resp_rdy_o    (resp_rdy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mst.ar_valid = 1'b0;
    mst.ar_addr  = '0;
    mst.ar_qos   = '0;
    mst.r_ready  = 1'b0;
    reqst_rdy    = '0;
    resp_val     = '0;
    resp_data    = '0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    clear_inputs();
    step();
    step();
    tests++; if (reqst_val !== 4'b0000) begin fails++; $display("FAIL rst_val: got %b want 0000", reqst_val); end
    tests++; if (reqst_data !== '0) begin fails++; $display("FAIL rst_data: got %h want 0", reqst_data); end
    tests++; if (reqst_qos !== '0) begin fails++; $display("FAIL rst_qos: got %h want 0", reqst_qos); end
    tests++; if (resp_rdy !== 4'b0000) begin fails++; $display("FAIL rst_resp_rdy: got %b want 0000", resp_rdy); end
    tests++; if (mst.ar_ready !== 1'b1) begin fails++; $display("FAIL rst_ar_ready: got %b want 1", mst.ar_ready); end
    tests++; if (mst.r_valid !== 1'b0) begin fails++; $display("FAIL rst_r_valid: got %b want 0", mst.r_valid); end
    @(negedge clk);
    rstn = 1'b1;
    step();
  endtask

  task automatic test_single_read();
    mst.ar_addr  = 32'h1000_0040;
    mst.ar_qos   = 4'd5;
    mst.ar_valid = 1'b1;
    #1;
    tests++; if (mst.ar_ready !== 1'b1) begin fails++; $display("FAIL sr_ar_ready: got %b want 1", mst.ar_ready); end
    step();
    mst.ar_valid = 1'b0;
    tests++; if (reqst_val !== 4'b0010) begin fails++; $display("FAIL sr_val: got %b want 0010", reqst_val); end
    tests++; if (reqst_qos[1] !== 4'd5) begin fails++; $display("FAIL sr_qos: got %0d want 5", reqst_qos[1]); end
    tests++; if (reqst_data[1] !== 32'h1000_0040) begin fails++; $display("FAIL sr_addr: got %h want 10000040", reqst_data[1]); end
    tests++; if (mst.ar_ready !== 1'b0) begin fails++; $display("FAIL sr_ar_busy: got %b want 0", mst.ar_ready); end
    reqst_rdy = 4'b0010;
    step();
    reqst_rdy = '0;
    tests++; if (reqst_val !== 4'b0000) begin fails++; $display("FAIL sr_val_drop: got %b want 0000", reqst_val); end
    tests++; if (mst.r_valid !== 1'b0) begin fails++; $display("FAIL sr_no_early_r: got %b want 0", mst.r_valid); end
    resp_val     = 4'b0010;
    resp_data[1] = {32'hDEAD_BEEF, 2'b00};
    mst.r_ready  = 1'b1;
    #1;
    tests++; if (mst.r_valid !== 1'b1) begin fails++; $display("FAIL sr_r_valid: got %b want 1", mst.r_valid); end
    tests++; if (mst.r_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL sr_r_data: got %h want deadbeef", mst.r_data); end
    tests++; if (mst.r_resp !== 2'b00) begin fails++; $display("FAIL sr_r_resp: got %b want 00", mst.r_resp); end
    tests++; if (resp_rdy !== 4'b0010) begin fails++; $display("FAIL sr_resp_rdy: got %b want 0010", resp_rdy); end
    step();
    tests++; if (mst.ar_ready !== 1'b1) begin fails++; $display("FAIL sr_idle: got %b want 1", mst.ar_ready); end
    tests++; if (mst.r_valid !== 1'b0) begin fails++; $display("FAIL sr_one_beat: got %b want 0", mst.r_valid); end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    mst.ar_addr  = 32'h1000_0080;
    mst.ar_qos   = 4'd3;
    mst.ar_valid = 1'b1;
    step();
    mst.ar_valid = 1'b0;
    mst.ar_addr  = 32'h2000_0000;
    for (int k = 0; k < 4; k++) begin
      tests++; if (reqst_val !== 4'b0010) begin fails++; $display("FAIL bp_val_hold%0d: got %b want 0010", k, reqst_val); end
      tests++; if (reqst_data[1] !== 32'h1000_0080) begin fails++; $display("FAIL bp_addr_hold%0d: got %h want 10000080", k, reqst_data[1]); end
      tests++; if (mst.ar_ready !== 1'b0) begin fails++; $display("FAIL bp_ar_ready%0d: got %b want 0", k, mst.ar_ready); end
      step();
    end
    reqst_rdy = 4'b0010;
    step();
    reqst_rdy    = '0;
    resp_val     = 4'b0010;
    resp_data[1] = {32'h1234_5678, 2'b00};
    #1;
    for (int k = 0; k < 3; k++) begin
      tests++; if (mst.r_valid !== 1'b1) begin fails++; $display("FAIL bp_r_valid%0d: got %b want 1", k, mst.r_valid); end
      tests++; if (resp_rdy !== 4'b0000) begin fails++; $display("FAIL bp_resp_rdy_low%0d: got %b want 0000", k, resp_rdy); end
      tests++; if (mst.ar_ready !== 1'b0) begin fails++; $display("FAIL bp_ar_wait%0d: got %b want 0", k, mst.ar_ready); end
      step();
    end
    mst.r_ready = 1'b1;
    #1;
    tests++; if (resp_rdy !== 4'b0010) begin fails++; $display("FAIL bp_resp_rdy_high: got %b want 0010", resp_rdy); end
    tests++; if (mst.r_data !== 32'h1234_5678) begin fails++; $display("FAIL bp_r_data: got %h want 12345678", mst.r_data); end
    step();
    tests++; if (mst.ar_ready !== 1'b1) begin fails++; $display("FAIL bp_idle: got %b want 1", mst.ar_ready); end
    clear_inputs();
  endtask

  task automatic test_unmapped();
    mst.ar_addr  = 32'hF000_0000;
    mst.ar_qos   = 4'd2;
    mst.ar_valid = 1'b1;
    step();
    mst.ar_valid = 1'b0;
`ifdef LITEIC_DECERR_EN
    tests++; if (mst.r_valid !== 1'b1) begin fails++; $display("FAIL um_r_valid: got %b want 1", mst.r_valid); end
    tests++; if (mst.r_resp !== 2'b11) begin fails++; $display("FAIL um_r_resp: got %b want 11", mst.r_resp); end
    tests++; if (mst.r_data !== 32'h0) begin fails++; $display("FAIL um_r_data: got %h want 0", mst.r_data); end
    tests++; if (reqst_val !== 4'b0000) begin fails++; $display("FAIL um_no_req: got %b want 0000", reqst_val); end
    step();
    tests++; if (mst.r_valid !== 1'b1) begin fails++; $display("FAIL um_r_hold: got %b want 1", mst.r_valid); end
    mst.r_ready = 1'b1;
    step();
    tests++; if (mst.ar_ready !== 1'b1) begin fails++; $display("FAIL um_idle: got %b want 1", mst.ar_ready); end
`else
    tests++; if (reqst_val !== 4'b0001) begin fails++; $display("FAIL um_default_val: got %b want 0001", reqst_val); end
    tests++; if (reqst_data[0] !== 32'hF000_0000) begin fails++; $display("FAIL um_default_addr: got %h want f0000000", reqst_data[0]); end
    reqst_rdy = 4'b0001;
    step();
    reqst_rdy    = '0;
    resp_val     = 4'b0001;
    resp_data[0] = {32'hCAFE_F00D, 2'b10};
    mst.r_ready  = 1'b1;
    #1;
    tests++; if (mst.r_valid !== 1'b1) begin fails++; $display("FAIL um_r_valid: got %b want 1", mst.r_valid); end
    tests++; if (mst.r_data !== 32'hCAFE_F00D) begin fails++; $display("FAIL um_r_data: got %h want cafef00d", mst.r_data); end
    tests++; if (mst.r_resp !== 2'b10) begin fails++; $display("FAIL um_r_resp: got %b want 10", mst.r_resp); end
    step();
    tests++; if (mst.ar_ready !== 1'b1) begin fails++; $display("FAIL um_idle: got %b want 1", mst.ar_ready); end
`endif
    clear_inputs();
  endtask

  task automatic test_spurious();
    mst.ar_addr  = 32'h1000_0000;
    mst.ar_valid = 1'b1;
    step();
    mst.ar_valid = 1'b0;
    reqst_rdy    = 4'b0010;
    step();
    reqst_rdy    = '0;
    resp_val     = 4'b0100;
    resp_data[2] = {32'hBAD0_BAD0, 2'b00};
    mst.r_ready  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      tests++; if (mst.r_valid !== 1'b0) begin fails++; $display("FAIL sp_r_valid%0d: got %b want 0", k, mst.r_valid); end
      tests++; if (resp_rdy !== 4'b0010) begin fails++; $display("FAIL sp_resp_rdy%0d: got %b want 0010", k, resp_rdy); end
      step();
    end
    tests++; if (mst.ar_ready !== 1'b0) begin fails++; $display("FAIL sp_still_wait: got %b want 0", mst.ar_ready); end
    resp_val     = 4'b0110;
    resp_data[1] = {32'h0BAD_F00D, 2'b00};
    #1;
    tests++; if (mst.r_data !== 32'h0BAD_F00D) begin fails++; $display("FAIL sp_r_data: got %h want 0badf00d", mst.r_data); end
    step();
    tests++; if (mst.ar_ready !== 1'b1) begin fails++; $display("FAIL sp_idle: got %b want 1", mst.ar_ready); end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    mst.ar_addr  = 32'h2000_0010;
    mst.ar_qos   = 4'd7;
    mst.ar_valid = 1'b1;
    step();
    mst.ar_valid = 1'b0;
    tests++; if (reqst_val !== 4'b0100) begin fails++; $display("FAIL rm_val: got %b want 0100", reqst_val); end
    #2;
    rstn = 1'b0;
    #1;
    tests++; if (reqst_val !== 4'b0000) begin fails++; $display("FAIL rm_async_val: got %b want 0000", reqst_val); end
    tests++; if (reqst_data !== '0) begin fails++; $display("FAIL rm_async_data: got %h want 0", reqst_data); end
    tests++; if (reqst_qos !== '0) begin fails++; $display("FAIL rm_async_qos: got %h want 0", reqst_qos); end
    clear_inputs();
    @(negedge clk);
    rstn = 1'b1;
    step();
    tests++; if (mst.ar_ready !== 1'b1) begin fails++; $display("FAIL rm_ar_ready: got %b want 1", mst.ar_ready); end
    mst.ar_addr  = 32'h2000_0020;
    mst.ar_qos   = 4'd1;
    mst.ar_valid = 1'b1;
    step();
    mst.ar_valid = 1'b0;
    tests++; if (reqst_qos[2] !== 4'd1) begin fails++; $display("FAIL rm_qos2: got %0d want 1", reqst_qos[2]); end
    reqst_rdy = 4'b0100;
    step();
    reqst_rdy    = '0;
    resp_val     = 4'b0100;
    resp_data[2] = {32'h55AA_55AA, 2'b00};
    mst.r_ready  = 1'b1;
    #1;
    tests++; if (mst.r_data !== 32'h55AA_55AA) begin fails++; $display("FAIL rm_r_data: got %h want 55aa55aa", mst.r_data); end
    step();
    tests++; if (mst.ar_ready !== 1'b1) begin fails++; $display("FAIL rm_idle: got %b want 1", mst.ar_ready); end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    int last_ar;
    int done;
    int n;
    logic [3:0]  exp_sel;
    logic [31:0] exp_data;
    last_ar     = 0;
    done        = 0;
    reqst_rdy   = 4'b1111;
    resp_val    = 4'b0011;
    mst.r_ready = 1'b1;
    mst.ar_addr  = 32'h0000_0100;
    mst.ar_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_sel      = (i % 2 == 1) ? 4'b0010 : 4'b0001;
      exp_data     = (i % 2 == 1) ? (32'hB000_0000 + 32'(i)) : (32'hA000_0000 + 32'(i));
      resp_data[0] = {32'hA000_0000 + 32'(i), 2'b00};
      resp_data[1] = {32'hB000_0000 + 32'(i), 2'b01};
      n = 0;
      while (mst.ar_ready !== 1'b1 && n < 10) begin step(); n++; end
      tests++; if (mst.ar_ready !== 1'b1) begin fails++; $display("FAIL b2b_ar_timeout%0d: got %b want 1", i, mst.ar_ready); end
      if (i > 0) begin
        tests++; if (cyc - last_ar < 3) begin fails++; $display("FAIL b2b_period%0d: got %0d want >=3", i, cyc - last_ar); end
      end
      last_ar = cyc;
      step();
      mst.ar_valid = 1'b0;
      tests++; if (reqst_val !== exp_sel) begin fails++; $display("FAIL b2b_val%0d: got %b want %b", i, reqst_val, exp_sel); end
      step();
      n = 0;
      while (mst.r_valid !== 1'b1 && n < 10) begin step(); n++; end
      tests++; if (mst.r_data !== exp_data) begin fails++; $display("FAIL b2b_data%0d: got %h want %h", i, mst.r_data, exp_data); end
      if (mst.r_valid === 1'b1 && mst.r_data === exp_data) done++;
      if (i < 7) begin
        mst.ar_addr  = ((i % 2 == 0) ? 32'h1000_0000 : 32'h0) + 32'h100 + 32'((i + 1) * 4);
        mst.ar_valid = 1'b1;
        #1;
        tests++; if (mst.ar_ready !== 1'b0) begin fails++; $display("FAIL b2b_ar_blocked%0d: got %b want 0", i, mst.ar_ready); end
      end
      step();
    end
    tests++; if (done !== 8) begin fails++; $display("FAIL b2b_count: got %0d want 8", done); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_backpressure();
    test_unmapped();
    test_spurious();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
